// File: rtl/pc_gen.sv
// Program-counter generator: sequential / ALU / trap / exception-return sources,
// misaligned-target trapping, and a one-entry redirect buffer that covers stalls.
module pc_gen #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] alu_tgt_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_four_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o,
  output logic            pend_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;
  localparam logic [1:0] SEL_EPC  = 2'b11;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] buf_tgt_q, buf_tgt_d;
  logic            buf_trap_q, buf_trap_d;
  logic            buf_mis_q, buf_mis_d;

  // Source decode: raw target, misalignment check and trap substitution
  logic [XLEN-1:0] trap_eff;
  logic [XLEN-1:0] raw_tgt;
  logic            raw_mis;
  logic            redirect;
  logic [XLEN-1:0] new_tgt;
  logic            new_trap;

  always_comb begin
    trap_eff = {trap_vec_i[XLEN-1:2], 2'b00};
    raw_tgt  = (sel_i == SEL_ALU) ? alu_tgt_i : epc_i;
    raw_mis  = ((sel_i == SEL_ALU) || (sel_i == SEL_EPC)) && (raw_tgt[1:0] != 2'b00);
    redirect = (sel_i != SEL_SEQ);
    new_trap = (sel_i == SEL_TRAP) || raw_mis;
    new_tgt  = new_trap ? trap_eff : raw_tgt;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bad_d      = bad_q;
    mis_d      = 1'b0;
    buf_tgt_d  = buf_tgt_q;
    buf_trap_d = buf_trap_q;
    buf_mis_d  = buf_mis_q;

    case (state_q)
      RUN: begin
        if (!stall_i) begin
          pc_d  = redirect ? new_tgt : pc_q + XLEN'(4);
          mis_d = raw_mis;
          if (raw_mis) bad_d = raw_tgt;
        end else if (redirect) begin
          buf_tgt_d  = new_tgt;
          buf_trap_d = new_trap;
          buf_mis_d  = raw_mis;
          if (raw_mis) bad_d = raw_tgt;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          // A trap arriving on the release cycle pre-empts the buffered target
          if (sel_i == SEL_TRAP) begin
            pc_d = trap_eff;
          end else begin
            pc_d  = buf_tgt_q;
            mis_d = buf_mis_q;
          end
          buf_tgt_d  = '0;
          buf_trap_d = 1'b0;
          buf_mis_d  = 1'b0;
          state_d    = RUN;
        end else if (redirect && (new_trap || !buf_trap_q)) begin
          buf_tgt_d  = new_tgt;
          buf_trap_d = new_trap;
          buf_mis_d  = raw_mis;
          if (raw_mis) bad_d = raw_tgt;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      bad_q      <= '0;
      mis_q      <= 1'b0;
      buf_tgt_q  <= '0;
      buf_trap_q <= 1'b0;
      buf_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bad_q      <= bad_d;
      mis_q      <= mis_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_trap_q <= buf_trap_d;
      buf_mis_q  <= buf_mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_four_o  = pc_q + XLEN'(4);
  assign misalign_o = mis_q;
  assign bad_addr_o = bad_q;
  assign pend_o     = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic against a queue-based
// reference model of the redirect/stall/trap rules.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RVEC = 32'h0000_0000;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic [1:0]      sel;
  logic [XLEN-1:0] alu_tgt, trap_vec, epc;
  logic [XLEN-1:0] pc, pc_four, bad_addr;
  logic            misalign, pend;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RVEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .sel_i(sel),
    .alu_tgt_i(alu_tgt), .trap_vec_i(trap_vec), .epc_i(epc),
    .pc_o(pc), .pc_four_o(pc_four), .misalign_o(misalign),
    .bad_addr_o(bad_addr), .pend_o(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tgt;
    bit          trap;
    bit          mis;
  } entry_t;

  // Reference state: a pending redirect is simply a non-empty queue
  entry_t      pendq[$];
  logic [31:0] m_pc, m_bad;
  bit          m_mis;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       pc,       m_pc);
    check({tag, ".pc_four"},  pc_four,  m_pc + 32'd4);
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
    check({tag, ".bad_addr"}, bad_addr, m_bad);
    check({tag, ".pend"},     {31'd0, pend}, {31'd0, (pendq.size() != 0)});
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_bad = 32'd0;
    m_mis = 1'b0;
    pendq.delete();
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic cycle(input string tag, input bit s, input logic [1:0] sl,
                       input logic [31:0] a, input logic [31:0] tv, input logic [31:0] e);
    logic [31:0] eff, raw, tgt;
    bit          is_mis, is_trap;
    entry_t      ent;
    stall = s; sel = sl; alu_tgt = a; trap_vec = tv; epc = e;
    eff     = tv & 32'hFFFF_FFFC;
    raw     = (sl == 2'd1) ? a : e;
    is_mis  = (sl == 2'd1 || sl == 2'd3) && (raw % 4 != 0);
    is_trap = (sl == 2'd2) || is_mis;
    tgt     = is_trap ? eff : raw;
    ent     = '{tgt: tgt, trap: is_trap, mis: is_mis};
    m_mis   = 1'b0;
    if (pendq.size() == 0) begin
      if (!s) begin
        m_pc  = (sl == 2'd0) ? m_pc + 32'd4 : tgt;
        m_mis = is_mis;
        if (is_mis) m_bad = raw;
      end else if (sl != 2'd0) begin
        pendq.push_back(ent);
        if (is_mis) m_bad = raw;
      end
    end else begin
      if (!s) begin
        if (sl == 2'd2) m_pc = eff;
        else begin
          m_pc  = pendq[0].tgt;
          m_mis = pendq[0].mis;
        end
        pendq.delete();
      end else if (sl != 2'd0 && (is_trap || !pendq[0].trap)) begin
        pendq[0] = ent;
        if (is_mis) m_bad = raw;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset pulse asserted well away from the active edge
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; sel = 2'd0;
    alu_tgt = '0; trap_vec = '0; epc = '0;
    model_reset();
    #3;
    check_all("reset");
    #4;
    rst_n = 1'b1;

    // Sequential fetch from reset
    cycle("seq1", 0, 2'd0, 0, 0, 0);
    cycle("seq2", 0, 2'd0, 0, 0, 0);
    cycle("seq3", 0, 2'd0, 0, 0, 0);
    check("seq3.pc_lit", pc, 32'h0000_000C);

    // Branch then misaligned branch trapping to the vector
    cycle("to100", 0, 2'd1, 32'h100, 0, 0);
    cycle("br2000", 0, 2'd1, 32'h2000, 0, 0);
    check("br2000.pc_lit", pc, 32'h2000);
    cycle("mis2002", 0, 2'd1, 32'h2002, 32'h8000_0003, 0);
    check("mis2002.pc_lit", pc, 32'h8000_0000);
    check("mis2002.bad_lit", bad_addr, 32'h2002);
    cycle("mis_clear", 0, 2'd0, 0, 0, 0);

    // Redirect buffered behind a stall
    cycle("to40", 0, 2'd1, 32'h40, 0, 0);
    cycle("cap500", 1, 2'd1, 32'h500, 0, 0);
    cycle("hold1", 1, 2'd0, 0, 0, 0);
    cycle("hold2", 1, 2'd0, 0, 0, 0);
    check("hold2.pc_lit", pc, 32'h40);
    cycle("rel500", 0, 2'd0, 0, 0, 0);
    check("rel500.pc_lit", pc, 32'h500);

    // Buffered trap is not displaced by a non-trap redirect
    cycle("cap800", 1, 2'd2, 0, 32'h800, 0);
    cycle("epc_drop", 1, 2'd3, 0, 0, 32'h300);
    cycle("rel800", 0, 2'd0, 0, 0, 0);
    check("rel800.pc_lit", pc, 32'h800);

    // Trap on release wins over the buffered target
    cycle("cap500b", 1, 2'd1, 32'h500, 0, 0);
    cycle("rel900", 0, 2'd2, 0, 32'h900, 0);
    check("rel900.pc_lit", pc, 32'h900);

    // Misaligned capture: bad_addr now, misalign only at release
    cycle("cap703", 1, 2'd1, 32'h703, 32'hA00, 0);
    cycle("hold703", 1, 2'd1, 32'h1000, 0, 0);
    cycle("rel703", 0, 2'd3, 0, 0, 32'h444);

    // Wrap-around
    cycle("toFFC", 0, 2'd1, 32'hFFFF_FFFC, 0, 0);
    cycle("wrap", 0, 2'd0, 0, 0, 0);
    check("wrap.pc_lit", pc, 32'h0);

    // Reset in the middle of a HOLD
    cycle("cap_rst", 1, 2'd1, 32'h600, 0, 0);
    async_reset("rst_hold");
    cycle("post_rst", 0, 2'd0, 0, 0, 0);
    check("post_rst.pc_lit", pc, RVEC + 32'd4);

    // Random traffic, biased toward stalls and low-bit misalignment
    for (int i = 0; i < 400; i++) begin
      bit          s;
      logic [1:0]  sl;
      logic [31:0] a, tv, e;
      s  = ($urandom_range(0, 2) == 0);
      sl = 2'($urandom_range(0, 3));
      a  = $urandom;
      tv = $urandom;
      e  = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) e = e & 32'hFFFF_FFFC;
      if ($urandom_range(0, 60) == 0) async_reset("rnd_rst");
      cycle("rnd", s, sl, a, tv, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits; any value of 16 or more SHALL be supported.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset; width XLEN.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port stall_i  input  1  1 = hold PC this cycle.
REQ-006 Port sel_i  input  2  next-PC source: 00 sequential, 01 ALU target, 10 trap vector, 11 exception return.
REQ-007 Port alu_tgt_i  input  XLEN  branch/jump target from ALU.
REQ-008 Port trap_vec_i  input  XLEN  trap handler address.
REQ-009 Port epc_i  input  XLEN  exception return address.
REQ-010 Port pc_o  output  XLEN  current PC, registered.
REQ-011 Port pc_four_o  output  XLEN  pc_o + 4, combinational.
REQ-012 Port misalign_o  output  1  one-cycle pulse, registered: misaligned redirect taken.
REQ-013 Port bad_addr_o  output  XLEN  last misaligned target, registered.
REQ-014 Port pend_o  output  1  1 = a redirect is buffered behind a stall.

Function
REQ-015 pc_four_o SHALL equal pc_o + 4 modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal and SHALL raise no flag.
REQ-016 Effective trap target SHALL be trap_vec_i with bits [1:0] forced to 0.
REQ-017 Redirect SHALL mean sel_i != 00; a redirect target with sel 01 or 11 SHALL be misaligned when target[1:0] != 00.
REQ-018 A misaligned 01/11 target SHALL be replaced by the effective trap target, bad_addr_o SHALL load the raw target, and misalign_o SHALL pulse for one cycle at the edge on which the replacement is applied to pc_o.
REQ-019 The state machine SHALL have two states: RUN (pend_o=0) and HOLD (pend_o=1).
REQ-020 RUN, stall_i=0: pc_o SHALL load the selected (misalign-corrected) source at the next edge; latency is one cycle.
REQ-021 RUN, stall_i=1, sel_i=00: pc_o SHALL hold and the state SHALL remain RUN.
REQ-022 RUN, stall_i=1, redirect: pc_o SHALL hold; the corrected target and its type (trap or not) SHALL be captured in a one-entry buffer; next state SHALL be HOLD.
REQ-023 HOLD, stall_i=1: a new trap (sel 10 or misaligned) SHALL overwrite the buffer; a new non-trap redirect SHALL overwrite only a non-trap entry; sel 00 SHALL leave the buffer unchanged.
REQ-024 HOLD, stall_i=0: pc_o SHALL load the buffered target, except that a simultaneous sel_i=10 SHALL win and load the effective trap target; the state SHALL go to RUN; any other sel_i that cycle SHALL be dropped.
REQ-025 misalign_o SHALL pulse only when a buffered or direct misaligned target is applied to pc_o, never at capture time; bad_addr_o SHALL be loaded at capture time.
REQ-026 No other output SHALL change while pc_o holds, except bad_addr_o on capture.

Reset
REQ-027 While rst_n=0, outputs SHALL be pc_o=RESET_VEC, misalign_o=0, bad_addr_o=0, pend_o=0, and the state SHALL be RUN, with the buffer cleared; these SHALL apply immediately, without waiting for a clock edge.
REQ-028 Reset asserted in HOLD SHALL discard the buffered redirect.
REQ-029 The first edge after rst_n rises SHALL apply normal RUN rules.

Verification
REQ-030 Reset, then three cycles of sel=00 with no stall -> pc_o = 0x0, 0x4, 0x8, 0xC; pc_four_o = pc_o+4 in every cycle.
REQ-031 From pc_o=0x100, sel=01, alu_tgt=0x2000 -> pc_o=0x2000 next cycle; then sel=01, alu_tgt=0x2002, trap_vec=0x80000003 -> pc_o=0x80000000, misalign_o=1 for one cycle, bad_addr_o=0x2002.
REQ-032 At pc_o=0x40, stall=1 with sel=01, tgt=0x500 for 1 cycle, then stall=1 with sel=00 for 2 cycles, then stall=0 -> pc_o holds 0x40 with pend_o=1 throughout; pc_o=0x500 and pend_o=0 after the release edge.
REQ-033 HOLD with buffered trap 0x800: stall=1 with sel=11, epc=0x300 -> buffer unchanged; on release pc_o=0x800. HOLD with buffered 0x500 released with sel=10, trap_vec=0x900 -> pc_o=0x900.
REQ-034 pc_o=0xFFFFFFFC, sel=00 -> pc_o=0x0 and misalign_o=0.
REQ-035 Assert rst_n=0 mid-cycle in HOLD -> pc_o=RESET_VEC and pend_o=0 before the next edge; after release, sel=00 -> pc_o=RESET_VEC+4.
